alu_pipe_hs: RTL and testbench

Parametrised, two-stage pipelined ALU with valid/ready handshakes on input and output. It is the successor to the team's free-running registered ALU. It adds generic width, defined (non-X) results for illegal opcodes, corrected subtract overflow/carry semantics, backpressure, and a saturating illegal-op counter. It sits between an operand-issue stage and a result-writeback consumer.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_core.sv | 75 +++++++
 rtl/alu_pipe_hs.sv | 103 ++++++++++
 tb/tb_alu_pipe_hs.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, flag bundle and the
// opcode legality check used by the datapath.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SLL  = 4'b0001,
      OP_SLT  = 4'b0010,
      OP_SLTU = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SRL  = 4'b0101,
      OP_OR   = 4'b0110,
      OP_AND  = 4'b0111,
      OP_SUB  = 4'b1000,
      OP_SRA  = 4'b1101
   } op_e;

   typedef struct packed {
      logic v;
      logic z;
      logic n;
      logic c;
      logic err;
   } flags_t;

   function automatic logic is_legal(op_e op);
      case (op)
         OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
         OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: is_legal = 1'b1;
         default:                               is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath. Produces the result and the flag bundle
// for one operand beat; illegal opcodes yield a zero result with err set.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] res,
   output flags_t           flags
);

   logic [SHW-1:0]        sh;
   logic [WIDTH:0]        add_sum;
   logic [WIDTH:0]        sub_sum;
   logic [WIDTH:0]        sll_ext;
   logic [WIDTH:0]        srl_ext;
   logic signed [WIDTH:0] sra_ext;
   logic                  slt;
   logic                  sltu;
   logic                  legal;
   logic [WIDTH-1:0]      res_i;
   logic                  v_i;
   logic                  c_i;

   assign sh      = b[SHW-1:0];
   assign add_sum = {1'b0, a} + {1'b0, b};
   // Subtract as a + ~b + 1 so the carry out reads as "no borrow".
   assign sub_sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

   // One extra bit on the shifted-out side captures the last bit lost by the
   // shift; with a zero shift amount that bit is the padding zero.
   assign sll_ext = {1'b0, a} << sh;
   assign srl_ext = {a, 1'b0} >> sh;
   assign sra_ext = $signed({a, 1'b0}) >>> sh;

   assign slt   = $signed(a) < $signed(b);
   assign sltu  = a < b;
   assign legal = is_legal(op_e'(op));

   // Result, carry and overflow selection per opcode.
   always_comb begin
      res_i = '0;
      v_i   = 1'b0;
      c_i   = 1'b0;
      case (op_e'(op))
         OP_ADD: begin
            res_i = add_sum[WIDTH-1:0];
            c_i   = add_sum[WIDTH];
            v_i   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            res_i = sub_sum[WIDTH-1:0];
            c_i   = sub_sum[WIDTH];
            v_i   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLL:  {c_i, res_i} = sll_ext;
         OP_SRL:  {res_i, c_i} = srl_ext;
         OP_SRA:  {res_i, c_i} = sra_ext;
         OP_SLT:  res_i = {{(WIDTH-1){1'b0}}, slt};
         OP_SLTU: res_i = {{(WIDTH-1){1'b0}}, sltu};
         OP_XOR:  res_i = a ^ b;
         OP_OR:   res_i = a | b;
         OP_AND:  res_i = a & b;
         default: ;
      endcase
   end

   assign res   = res_i;
   assign flags = '{v: v_i, z: (res_i == '0), n: res_i[WIDTH-1], c: c_i, err: !legal};

endmodule

// File: rtl/alu_pipe_hs.sv
// Two-stage ALU pipeline with valid/ready on both sides. Stage 1 captures the
// operands, stage 2 captures the alu_core result. Ready ripples back
// combinationally from out_ready; there is no skid buffer.
module alu_pipe_hs
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH),
   parameter int ERRW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             v,
   output logic             z,
   output logic             n,
   output logic             c,
   output logic             err,
   output logic [ERRW-1:0]  err_cnt
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [3:0]       s1_op;
   logic             s1_ready;
   logic             s2_ready;
   logic             s2_load;
   logic [WIDTH-1:0] core_res;
   flags_t           core_flags;
   flags_t           flags_q;

   assign s2_ready = !out_valid || out_ready;
   assign s1_ready = !s1_valid || s2_ready;
   assign in_ready = s1_ready;
   assign s2_load  = s2_ready && s1_valid;

   alu_core #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_core (
      .a     (s1_a),
      .b     (s1_b),
      .op    (s1_op),
      .res   (core_res),
      .flags (core_flags)
   );

   // Stage 1: operand capture whenever the stage can advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
      end else if (s1_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a  <= a;
            s1_b  <= b;
            s1_op <= op;
         end
      end
   end

   // Stage 2: result/flag capture; holds everything while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         res       <= '0;
         flags_q   <= '0;
      end else if (s2_ready) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            res     <= core_res;
            flags_q <= core_flags;
         end
      end
   end

   // Saturating count of illegal beats, bumped as each one enters stage 2.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (s2_load && core_flags.err && (err_cnt != {ERRW{1'b1}})) begin
         err_cnt <= err_cnt + ERRW'(1);
      end
   end

   assign v   = flags_q.v;
   assign z   = flags_q.z;
   assign n   = flags_q.n;
   assign c   = flags_q.c;
   assign err = flags_q.err;

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Scoreboard bench for alu_pipe_hs: the driver pushes expected beats computed
// by a plain-arithmetic reference model, a negedge monitor pops and compares.
module tb_alu_pipe_hs;

   localparam int W = 32;

   typedef struct {
      logic [31:0] res;
      logic        v;
      logic        z;
      logic        n;
      logic        c;
      logic        err;
      logic [7:0]  cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [3:0]  op = '0;
   logic        out_valid;
   wire         out_ready;
   logic [31:0] res;
   logic        v, z, n, c, err;
   logic [7:0]  err_cnt;

   logic force_ready = 1'b1;
   logic rand_ready  = 1'b0;
   logic rnd_ready   = 1'b1;
   assign out_ready = rand_ready ? rnd_ready : force_ready;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_acc = 0;
   int   ill_cnt = 0;

   logic        hold = 1'b0;
   logic [31:0] held_res;
   logic [4:0]  held_flags;

   alu_pipe_hs #(.WIDTH(W), .ERRW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .v         (v),
      .z         (z),
      .n         (n),
      .c         (c),
      .err       (err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Reference model: signed/unsigned arithmetic on wide integers.
   function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      longint      sx, sy, ux, uy, r, u;
      int          sh;
      logic [31:0] t;
      e.res = '0; e.v = 1'b0; e.c = 1'b0; e.err = 1'b0; e.cnt = '0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'b0, x});
      uy = longint'({32'b0, y});
      sh = int'(y[4:0]);
      case (o)
         4'b0000: begin
            r = sx + sy; e.res = r[31:0];
            u = ux + uy; e.c = u[32];
            e.v = (r != longint'($signed(e.res)));
         end
         4'b1000: begin
            r = sx - sy; e.res = r[31:0];
            e.c = (x >= y);
            e.v = (r != longint'($signed(e.res)));
         end
         4'b0001: begin
            e.res = x << sh;
            if (sh != 0) begin t = x >> (32 - sh); e.c = t[0]; end
         end
         4'b0101: begin
            e.res = x >> sh;
            if (sh != 0) begin t = x >> (sh - 1); e.c = t[0]; end
         end
         4'b1101: begin
            e.res = 32'($signed(x) >>> sh);
            if (sh != 0) begin t = x >> (sh - 1); e.c = t[0]; end
         end
         4'b0010: e.res = {31'b0, (sx < sy)};
         4'b0011: e.res = {31'b0, (x < y)};
         4'b0100: e.res = x ^ y;
         4'b0110: e.res = x | y;
         4'b0111: e.res = x & y;
         default: e.err = 1'b1;
      endcase
      e.z = (e.res == 32'd0);
      e.n = e.res[31];
      return e;
   endfunction

   task automatic push_exp(input exp_t e);
      exp_t t;
      t = e;
      if (t.err && ill_cnt < 255) ill_cnt++;
      t.cnt = 8'(ill_cnt);
      sbq.push_back(t);
   endtask

   // Present one beat and hold it until accepted (bounded).
   task automatic send_e(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input exp_t e);
      bit done;
      done = 0;
      in_valid = 1'b1; op = o; a = x; b = y;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            push_exp(e);
            n_acc++;
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: got in_ready=0 for 500 cycles want acceptance");
      end
   endtask

   task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      send_e(o, x, y, model(o, x, y));
   endtask

   task automatic send_chk(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] r, input logic vv, input logic zz,
                           input logic nn, input logic cc);
      exp_t e;
      e.res = r; e.v = vv; e.z = zz; e.n = nn; e.c = cc; e.err = 1'b0; e.cnt = '0;
      send_e(o, x, y, e);
   endtask

   task automatic drain();
      for (int i = 0; i < 2000 && sbq.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk("drain_left", 64'(sbq.size()), 64'd0);
   endtask

   task automatic rand_beats(input int cnt);
      logic [31:0] x, y;
      logic [3:0]  o;
      for (int i = 0; i < cnt; i++) begin
         o = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 5))
            0:       x = 32'h7FFF_FFFF;
            1:       x = 32'h8000_0000;
            2:       x = 32'hFFFF_FFFF;
            default: x = $urandom;
         endcase
         y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
         send(o, x, y);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   // Monitor: stability under stall, then scoreboard compare on each transfer.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_hold", 64'({res, v, z, n, c, err}), 64'({held_res, held_flags}));
         end
         hold       = out_valid && !out_ready;
         held_res   = res;
         held_flags = {v, z, n, c, err};
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chk("unexpected_beat", 64'(out_valid), 64'd0);
            end else begin
               e = sbq.pop_front();
               chk("beat{res,v,z,n,c,err,cnt}",
                   64'({res, v, z, n, c, err, err_cnt}),
                   64'({e.res, e.v, e.z, e.n, e.c, e.err, e.cnt}));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_res", 64'(res), 64'd0);
      chk("rst_flags", 64'({v, z, n, c, err}), 64'd0);
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);

      // Directed arithmetic and shift cases with hand-derived results.
      send_chk(4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0, 1, 0);
      send_chk(4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000, 0, 1, 0, 1);
      send_chk(4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0, 1, 0);
      send_chk(4'b1000, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1, 0, 0, 1);
      send_chk(4'b0001, 32'h8000_0001, 32'd1, 32'h0000_0002, 0, 0, 0, 1);
      send_chk(4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0, 1, 0);
      send_chk(4'b0101, 32'h0000_0003, 32'd0, 32'h0000_0003, 0, 0, 0, 0);
      drain();

      // Backpressure: four XOR beats while the consumer stalls three cycles.
      force_ready = 1'b0;
      acc0 = n_acc;
      fork
         begin
            for (int i = 0; i < 4; i++) send(4'b0100, $urandom, $urandom);
         end
         begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_accepted", 64'(n_acc - acc0), 64'd2);
            @(posedge clk);
            #1;
            force_ready = 1'b1;
         end
      join
      drain();

      // Randomized traffic with random consumer stalls.
      rand_ready = 1'b1;
      rand_beats(400);
      rand_ready = 1'b0;
      force_ready = 1'b1;
      drain();

      // Illegal opcode flood drives the counter into saturation.
      for (int i = 0; i < 300; i++) send(4'b1111, $urandom, $urandom);
      drain();
      chk("err_cnt_sat", 64'(err_cnt), 64'd255);

      // Reset with two beats in flight: both must vanish.
      force_ready = 1'b0;
      send(4'b0100, $urandom, $urandom);
      send(4'b0100, $urandom, $urandom);
      rst = 1'b1;
      sbq.delete();
      ill_cnt = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst2_out_valid", 64'(out_valid), 64'd0);
      chk("rst2_err_cnt", 64'(err_cnt), 64'd0);
      chk("rst2_in_ready", 64'(in_ready), 64'd1);
      force_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst2_no_stale", 64'(out_valid), 64'd0);
      end
      @(posedge clk);
      #1;

      // Counter restarts from zero after reset.
      rand_beats(40);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
